// File: rtl/display_scanner.sv
// -----------------------------------------------------------------------------
// display_scanner
//
// Multiplexed driver for a 4-digit, 7-segment display. Each digit receives an
// equal time slot. The slot opens with a short blanking window, where every
// anode is off, to stop ghosting from the previous digit. After that window the
// selected digit is driven. New digit values wait in a pending register. They
// are transferred to the visible display register only at a frame boundary, so
// a frame never mixes old and new values.
//
// Parameters
//   CLOCK_FREQ   clk frequency in Hz
//   SCAN_HZ      full 4-digit frame refresh rate in Hz
//   BLANK_CYCLES blank cycles at the start of each digit slot
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   digits    four BCD digits, [3:0] = digit 0 (rightmost) .. [15:12] = digit 3
//   load      single-cycle strobe that captures digits into the pending register
//   blank_lz  leading-zero blanking enable (sampled live)
//   dp_mask   decimal-point enable per digit (sampled live)
//   seg       active-high segments, seg[0]=a .. seg[6]=g (registered)
//   an        active-low digit enables (registered)
//   dp        active-high decimal point for the selected digit (registered)
// -----------------------------------------------------------------------------
module display_scanner #(
    parameter int CLOCK_FREQ   = 10_000,
    parameter int SCAN_HZ      = 250,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int SLOT  = CLOCK_FREQ / (SCAN_HZ * 4);
    localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK_CYCLES);

    // A slot must hold the whole blank window plus at least one drive cycle.
    if (SLOT < BLANK_CYCLES + 1) begin : g_slot_check
        $error("display_scanner: slot of %0d cycles cannot hold %0d blank cycles plus a drive cycle",
               SLOT, BLANK_CYCLES);
    end

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    state_t           state_q, state_d;
    logic [15:0]      display_q, display_d;
    logic [15:0]      pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             dp_q, dp_d;

    logic             wrap;
    logic             commit;
    logic [3:0]       zero_nib;
    logic [3:0]       zero_from;
    logic             suppress;
    logic [3:0]       cur_code;

    // Active-high segment pattern, g..a. Non-decimal codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] pattern;
        case (code)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h40;
        endcase
        return pattern;
    endfunction

    // Slot timing, blank/drive sequencing and the pending-to-display transfer.
    // The commit happens on the wrap from digit 3 back to digit 0. At that
    // point the previous frame has fully finished.
    always_comb begin
        wrap         = (cnt_q == LAST_CNT);
        commit       = wrap && (digit_q == 2'd3);
        cnt_d        = wrap ? '0 : cnt_q + CNT_W'(1);
        digit_d      = wrap ? digit_q + 2'd1 : digit_q;
        state_d      = state_q;
        display_d    = display_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;

        case (state_q)
            BLANK: if (cnt_d >= BLANK_CNT) state_d = DRIVE;
            DRIVE: if (wrap && (BLANK_CYCLES > 0)) state_d = BLANK;
            default: state_d = BLANK;
        endcase

        if (commit && pend_valid_q) begin
            display_d    = pend_q;
            pend_valid_d = 1'b0;
        end

        // When a load arrives on the commit edge, the older pending value is
        // committed above and this load becomes the new pending value.
        if (load) begin
            pend_d       = digits;
            pend_valid_d = 1'b1;
        end
    end

    // Output decode from the current state. Registering the result adds one
    // cycle of delay, and that delay is the same for every slot.
    // Leading-zero suppression applies to digit i (i >= 1) when that digit and
    // every digit above it are zero.
    always_comb begin
        zero_nib[0]  = (display_q[3:0]   == 4'd0);
        zero_nib[1]  = (display_q[7:4]   == 4'd0);
        zero_nib[2]  = (display_q[11:8]  == 4'd0);
        zero_nib[3]  = (display_q[15:12] == 4'd0);
        zero_from[3] = zero_nib[3];
        zero_from[2] = zero_nib[2] & zero_from[3];
        zero_from[1] = zero_nib[1] & zero_from[2];
        zero_from[0] = zero_nib[0] & zero_from[1];
        suppress     = blank_lz && (digit_q != 2'd0) && zero_from[digit_q];
        cur_code     = display_q[{digit_q, 2'b00} +: 4];

        seg_d = 7'h00;
        an_d  = 4'hF;
        dp_d  = 1'b0;

        if ((state_q == DRIVE) && !suppress) begin
            seg_d = decode(cur_code);
            an_d  = ~(4'b0001 << digit_q);
            dp_d  = dp_mask[digit_q];
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            state_q      <= BLANK;
            display_q    <= 16'h0000;
            pend_q       <= 16'h0000;
            pend_valid_q <= 1'b0;
            seg_q        <= 7'h00;
            an_q         <= 4'hF;
            dp_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            state_q      <= state_d;
            display_q    <= display_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter CLOCK_FREQ, default 10_000; meaning: clk frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 250; meaning: full 4-digit frame refresh rate in Hz.
REQ-003 Parameter BLANK_CYCLES, default 2; meaning: anti-ghost blank cycles at the start of each digit slot.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 digits  input  16  four BCD digits: [3:0] = digit 0 (rightmost) … [15:12] = digit 3.
REQ-007 load  input  1  single-cycle strobe; captures digits into the pending register.
REQ-008 blank_lz  input  1  1 = leading-zero blanking enabled.
REQ-009 dp_mask  input  4  decimal-point enable per digit; bit i maps to digit i, sampled live.
REQ-010 seg  output  7  active-high segments: seg[0]=a … seg[6]=g.
REQ-011 an  output  4  active-low digit enables: an[i] low selects digit i.
REQ-012 dp  output  1  active-high decimal point for the selected digit.

Function
REQ-013 SLOT = CLOCK_FREQ / (SCAN_HZ*4), using integer division; the defaults give 10 cycles per digit slot.
REQ-014 Elaboration SHALL fail if SLOT < BLANK_CYCLES+1.
REQ-015 A slot counter counts 0..SLOT-1, then wraps to 0.
- On each wrap, the digit index advances 0→1→2→3→0.
REQ-016 State machine has two states, BLANK and DRIVE.
- BLANK holds while slot count < BLANK_CYCLES; DRIVE holds otherwise.
- BLANK→DRIVE occurs when the count reaches BLANK_CYCLES.
- DRIVE→BLANK occurs on slot wrap.
REQ-017 In BLANK: an=4'b1111, seg=0, dp=0.
REQ-018 In DRIVE with digit index i: an[i]=0 and the other three an bits are 1; seg=decode(display[i]); dp=dp_mask[i].
REQ-019 Decode table for seg[6:0] (hex, g..a):
- digits 0..9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
- codes 10–15: 40 (dash, segment g only).
REQ-020 load=1 copies digits into the pending register and sets pend_valid in the same edge.
REQ-021 At the start of slot 0 (the wrap from digit 3 to digit 0), pending is copied to display and pend_valid is cleared.
- Frames never mix old and new values (no tearing).
REQ-022 A load coinciding with the commit edge: the new digits go to pending and pend_valid stays 1; the previous pending value is committed.
REQ-023 Multiple loads within one frame: only the last one is committed.
REQ-024 Leading-zero blanking: with blank_lz=1, digit i (i≥1) is suppressed when display[i] and all higher digits are 0.
- A suppressed digit keeps an=4'b1111, seg=0, dp=0 for its whole slot.
- Digit 0 is never suppressed.
REQ-025 blank_lz is sampled live each cycle and does not wait for a frame boundary.
REQ-026 seg, an and dp are registered outputs, one cycle behind the internal state/count.
- The blank/drive timing is the same every slot.
REQ-027 First DRIVE after reset: digit 0 at cycle BLANK_CYCLES+1 after rst_n deasserts.

Reset
REQ-028 Asynchronous assertion of rst_n=0 forces:
- slot count = 0, digit index = 0, state = BLANK;
- display = 16'h0000, pending = 16'h0000, pend_valid = 0;
- seg = 0, an = 4'b1111, dp = 0.
REQ-029 Reset mid-frame discards any pending load.
- The first frame after release starts at digit 0 and shows 0000, subject to blank_lz.
REQ-030 Release of rst_n is used synchronously; the first count increment is on the first rising edge with rst_n=1.

Verification
REQ-031 Reset and release with defaults, digits never loaded -> an=1111 for 2 cycles, then an=1110 with seg=3F for 8 cycles, then 2 blank cycles, then an=1101 with seg=3F.
REQ-032 load with digits=16'h1234 mid-digit-2 slot -> current frame still shows 0000; the next frame shows:
- digit 0 = 4 (seg=66), digit 1 = 3 (4F), digit 2 = 2 (5B), digit 3 = 1 (06).
REQ-033 digits=16'h0070, blank_lz=1, committed:
- digit 3 and digit 2 stay an=1111 for their full slots;
- digit 1 drives 07;
- digit 0 drives 3F.
REQ-034 Loads of 16'h1111 and then 16'h2222 in the same frame, plus a load of 16'h3333 on the commit edge:
- the frame shows 2222 (seg=5B);
- the following frame shows 3333.
REQ-035 digits=16'hFA09, dp_mask=4'b0100:
- digits 3 and 2 show 40 (dash);
- dp=1 only during the DRIVE portion of the digit-2 slot.
REQ-036 Assert rst_n=0 during the DRIVE portion of digit 1 with a pending load outstanding:
- outputs go to reset values immediately, without waiting for a clock edge;
- after release the display shows 0000.
